// File: rtl/bk_pkg.sv
// Shared constants, row-index helpers and flag bundle for the Brent-Kung subtract pipe.
package bk_pkg;

    localparam int BK_DEFAULT_SIZE = 32;

    function automatic int bk_log2(input int n);
        return $clog2(n);
    endfunction

    // Up-sweep occupies rows [0, UP_END), down-sweep rows [UP_END, DOWN_END).
    function automatic int bk_up_end(input int n);
        return $clog2(n);
    endfunction

    function automatic int bk_down_end(input int n);
        return 2 * $clog2(n) - 1;
    endfunction

    typedef struct packed {
        logic bout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/bk_prefix_rows.sv
// Combinational Brent-Kung prefix rows ROW_FIRST..ROW_LAST (inclusive); no state, no handshake.
module bk_prefix_rows
    import bk_pkg::*;
#(
    parameter int ADDER_SIZE = BK_DEFAULT_SIZE,
    parameter int ROW_FIRST  = 0,
    parameter int ROW_LAST   = 0
) (
    input  logic [ADDER_SIZE-1:0] g_in,
    input  logic [ADDER_SIZE-1:0] p_in,
    output logic [ADDER_SIZE-1:0] g_out,
    output logic [ADDER_SIZE-1:0] p_out
);

    localparam int N    = ADDER_SIZE;
    localparam int LOG2 = bk_log2(N);

    for (genvar r = ROW_FIRST; r <= ROW_LAST; r++) begin : g_row
        // Rows below LOG2 sweep up with span 2^r; later rows sweep back down.
        localparam bit UP = (r < LOG2);
        localparam int K  = UP ? r : (2 * LOG2 - 2 - r);
        localparam int D  = 1 << K;

        logic [N-1:0] gi, pi, go, po;

        if (r == ROW_FIRST) begin : g_src
            assign gi = g_in;
            assign pi = p_in;
        end else begin : g_src
            assign gi = g_row[r-1].go;
            assign pi = g_row[r-1].po;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            localparam bit HIT = UP ? (((i + 1) % (2 * D)) == 0)
                                    : ((((i + 1) % (2 * D)) == D) && (i >= 2 * D));
            if (HIT) begin : g_cell
                gp_unit u_cell (
                    .g_hi (gi[i]),
                    .p_hi (pi[i]),
                    .g_lo (gi[i-D]),
                    .p_lo (pi[i-D]),
                    .g    (go[i]),
                    .p    (po[i])
                );
            end else begin : g_pass
                assign go[i] = gi[i];
                assign po[i] = pi[i];
            end
        end
    end

    assign g_out = g_row[ROW_LAST].go;
    assign p_out = g_row[ROW_LAST].po;

endmodule

// File: rtl/gp_unit.sv
// Prefix combine cell: (g,p) = (g_hi | p_hi & g_lo, p_hi & p_lo). Purely combinational.
module gp_unit (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/brent_kung_sub_pipe.sv
// Three-stage Brent-Kung subtractor op1 - op2 - bin with borrow/overflow/zero flags.
// Latency 3 cycles, 1 beat/cycle; a stalled output freezes every full stage behind it, bubbles collapse.
module brent_kung_sub_pipe
    import bk_pkg::*;
#(
    parameter int ADDER_SIZE = BK_DEFAULT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDER_SIZE-1:0] in_op1,
    input  logic [ADDER_SIZE-1:0] in_op2,
    input  logic                  in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDER_SIZE-1:0] out_res,
    output logic                  out_bout,
    output logic                  out_ovf,
    output logic                  out_zero
);

    localparam int N        = ADDER_SIZE;
    localparam int UP_END   = bk_up_end(N);
    localparam int DOWN_END = bk_down_end(N);

    typedef struct packed {
        logic [N-1:0] op1;
        logic [N-1:0] nop2;
        logic         cin;
        logic         g0;
        logic         p0;
    } s1_t;

    typedef struct packed {
        logic [N-1:0] g_up;
        logic [N-1:0] p_up;
        logic [N-1:0] p_raw;
        logic         cin;
        logic         op1_msb;
        logic         op2_msb;
    } s2_t;

    typedef struct packed {
        logic [N-1:0] res;
        flags_t       flags;
    } s3_t;

    logic v1, v2, v3;
    logic en1, en2, en3;
    s1_t  s1, s1_d;
    s2_t  s2, s2_d;
    s3_t  s3, s3_d;

    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    // Bit 0 absorbs the effective carry-in (~bin), so the prefix tree needs no separate cin input.
    always_comb begin
        s1_d      = '0;
        s1_d.op1  = in_op1;
        s1_d.nop2 = ~in_op2;
        s1_d.cin  = ~in_bin;
        s1_d.g0   = (in_op1[0] & ~in_op2[0]) | ((in_op1[0] ^ ~in_op2[0]) & ~in_bin);
        s1_d.p0   = 1'b0;
    end

    logic [N-1:0] p_raw, g_bit, p_bit, g_up, p_up;

    assign p_raw = s1.op1 ^ s1.nop2;
    assign g_bit = {s1.op1[N-1:1] & s1.nop2[N-1:1], s1.g0};
    assign p_bit = {p_raw[N-1:1], s1.p0};

    bk_prefix_rows #(
        .ADDER_SIZE (N),
        .ROW_FIRST  (0),
        .ROW_LAST   (UP_END - 1)
    ) u_up (
        .g_in  (g_bit),
        .p_in  (p_bit),
        .g_out (g_up),
        .p_out (p_up)
    );

    always_comb begin
        s2_d         = '0;
        s2_d.g_up    = g_up;
        s2_d.p_up    = p_up;
        s2_d.p_raw   = p_raw;
        s2_d.cin     = s1.cin;
        s2_d.op1_msb = s1.op1[N-1];
        s2_d.op2_msb = ~s1.nop2[N-1];
    end

    logic [N-1:0] g_dn, p_dn;

    bk_prefix_rows #(
        .ADDER_SIZE (N),
        .ROW_FIRST  (UP_END),
        .ROW_LAST   (DOWN_END - 1)
    ) u_down (
        .g_in  (s2.g_up),
        .p_in  (s2.p_up),
        .g_out (g_dn),
        .p_out (p_dn)
    );

    // Group propagates after the full tree all include P[0]=0 and carry no information.
    logic unused_p_dn;
    assign unused_p_dn = ^p_dn;

    always_comb begin
        s3_d            = '0;
        s3_d.res        = s2.p_raw ^ {g_dn[N-2:0], s2.cin};
        s3_d.flags.bout = ~g_dn[N-1];
        s3_d.flags.ovf  = (s2.op1_msb != s2.op2_msb) && (s3_d.res[N-1] != s2.op1_msb);
        s3_d.flags.zero = ~|s3_d.res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) s1 <= s1_d;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) s2 <= s2_d;
            end
            if (en3) begin
                v3 <= v2;
                if (v2) s3 <= s3_d;
            end
        end
    end

    assign out_valid = v3;
    assign out_res   = s3.res;
    assign out_bout  = s3.flags.bout;
    assign out_ovf   = s3.flags.ovf;
    assign out_zero  = s3.flags.zero;

endmodule

// File: tb/tb_brent_kung_sub_pipe.sv
// Scoreboarded random and directed bench for brent_kung_sub_pipe at ADDER_SIZE=32.
module tb_brent_kung_sub_pipe;

    localparam int N = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_op1 = '0;
    logic [N-1:0] in_op2 = '0;
    logic         in_bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_res;
    logic         out_bout, out_ovf, out_zero;

    brent_kung_sub_pipe #(.ADDER_SIZE(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_bout  (out_bout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pops = 0;
    bit   lat_check = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: plain wide arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
        exp_t         e;
        logic [N:0]   d;
        longint       s;
        d      = {1'b0, a} - {1'b0, b} - (N+1)'(bi);
        s      = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        e.res  = d[N-1:0];
        e.bout = d[N];
        e.ovf  = (s > SMAX) || (s < SMIN);
        e.zero = (d[N-1:0] == '0);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: pops on output handshake, checks hold stability while stalled.
    exp_t         em;
    bit           stalled = 1'b0;
    logic [N-1:0] hold_res;
    logic [2:0]   hold_flags;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                total++;
                if (!out_valid || out_res !== hold_res || {out_bout, out_ovf, out_zero} !== hold_flags) begin
                    bad++;
                    $display("FAIL hold: valid=%0b res=%0h flags=%0b want valid=1 res=%0h flags=%0b",
                             out_valid, out_res, {out_bout, out_ovf, out_zero}, hold_res, hold_flags);
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output: res=%0h with empty scoreboard", out_res);
                end else begin
                    em = q.pop_front();
                    pops++;
                    total++;
                    if (out_res !== em.res || out_bout !== em.bout || out_ovf !== em.ovf || out_zero !== em.zero) begin
                        bad++;
                        $display("FAIL result: got res=%0h bout=%0b ovf=%0b zero=%0b want res=%0h bout=%0b ovf=%0b zero=%0b",
                                 out_res, out_bout, out_ovf, out_zero, em.res, em.bout, em.ovf, em.zero);
                    end
                    if (lat_check) check("latency", 32'(cyc - em.cyc), 32'd3);
                end
            end
            stalled    = out_valid && !out_ready;
            hold_res   = out_res;
            hold_flags = {out_bout, out_ovf, out_zero};
        end
    end

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                        input bit use_fix, input exp_t fix);
        int   w;
        bit   done;
        exp_t e;
        w = 0;
        done = 1'b0;
        in_op1 = a;
        in_op2 = b;
        in_bin = bi;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (lat_check) check("flow_in_ready", 32'(in_ready), 32'd1);
            if (in_ready) begin
                e = use_fix ? fix : model(a, b, bi);
                e.cyc = cyc;
                q.push_back(e);
                done = 1'b1;
            end else if (++w > 50) begin
                check("send_timeout", 32'(in_ready), 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        out_ready = 1'b1;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [N-1:0] d_a  [5] = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000};
    logic [N-1:0] d_b  [5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h1234_5677, 32'h0000_0000};
    logic         d_bi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] d_r  [5] = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [2:0]   d_f  [5] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b100};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acc;
        int   p0;
        bit   pend;

        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_res", out_res, 32'd0);
        check("rst_flags", 32'({out_bout, out_ovf, out_zero}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #20 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed corners, back to back, exact latency checked.
        lat_check = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e.res  = d_r[i];
            e.bout = d_f[i][2];
            e.ovf  = d_f[i][1];
            e.zero = d_f[i][0];
            e.cyc  = 0;
            send(d_a[i], d_b[i], d_bi[i], 1'b1, e);
        end

        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, e);
        drain();
        lat_check = 1'b0;

        // Full stall: exactly three beats fit.
        out_ready = 1'b0;
        acc = 0;
        in_op1 = $urandom;
        in_op2 = $urandom;
        in_bin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(in_op1, in_op2, in_bin);
                e.cyc = cyc;
                q.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
            in_op1 = $urandom;
            in_op2 = $urandom;
            in_bin = 1'($urandom_range(0, 1));
        end
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;

        // Random valid and ready traffic.
        pend = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                in_op1 = $urandom;
                in_op2 = $urandom;
                in_bin = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                pend = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                e = model(in_op1, in_op2, in_bin);
                e.cyc = cyc;
                q.push_back(e);
                pend = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!pend) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, e);
        @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_res", out_res, 32'd0);
        check("async_rst_flags", 32'({out_bout, out_ovf, out_zero}), 32'd0);
        q.delete();
        p0 = pops;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        lat_check = 1'b1;
        send(32'h0000_00A0, 32'h0000_000A, 1'b1, 1'b0, e);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_pops", 32'(pops - p0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
